cu_sha: RTL and testbench
=========================

CU_SHA -- requirements
Module: cu_sha

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL provide port usr_clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port usr_reset_n, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of usr_clk.
REQ-004 The block SHALL provide port i_start, input, 1 bit: request to begin one hash computation; level-sampled.
REQ-005 The block SHALL provide port i_cnt_flag, input, 1 bit: from the external round counter; high when the final round (63) is reached.
REQ-006 The block SHALL provide port o_cnt_en, output, 1 bit: enables the external round counter.
REQ-007 The block SHALL provide port o_valid, output, 1 bit: hash result valid strobe.
REQ-008 The block SHALL provide port sel_1, output, 1 bit: datapath mux select; 0 = load initial hash/message values, 1 = select round feedback.

Function
REQ-009 The block SHALL be a Moore FSM with states IDLE, COMPUTE and DONE, held in a state register; outputs SHALL decode from the state only, with no combinational path from any input to any output.
REQ-010 IDLE outputs SHALL be: o_cnt_en=0, o_valid=0, sel_1=0.
REQ-011 COMPUTE outputs SHALL be: o_cnt_en=1, o_valid=0, sel_1=1.
REQ-012 DONE outputs SHALL be: o_cnt_en=0, o_valid=1, sel_1=1.
REQ-013 IDLE SHALL go to COMPUTE on a rising edge with i_start=1, else stay in IDLE; i_cnt_flag SHALL be ignored in IDLE.
REQ-014 COMPUTE SHALL go to DONE on a rising edge with i_cnt_flag=1, else stay in COMPUTE; i_start SHALL be ignored in COMPUTE, so deasserting it does not abort.
REQ-015 DONE SHALL last exactly one cycle and then go unconditionally to IDLE, so o_valid is a single-cycle pulse.
REQ-016 If i_start is still 1 on the cycle after DONE, the block SHALL start a new computation from IDLE under REQ-013, giving a one-cycle IDLE gap (sel_1=0) between runs.
REQ-017 Latency: o_cnt_en SHALL rise after the edge that samples i_start=1; o_valid SHALL rise after the edge that samples i_cnt_flag=1; o_cnt_en SHALL fall at that same edge.
REQ-018 Any unused or illegal state encoding SHALL return to IDLE on the next rising edge.

Reset
REQ-019 When usr_reset_n=0 at a rising edge, the state SHALL become IDLE, so o_cnt_en=0, o_valid=0, sel_1=0, regardless of i_start or i_cnt_flag, including X values.
REQ-020 Reset SHALL take priority over all transitions, including during COMPUTE or DONE (mid-operation abort); no output SHALL change asynchronously on usr_reset_n.
REQ-021 After release of reset, the block SHALL evaluate REQ-013 on the first rising edge with usr_reset_n=1.

Verification
REQ-022 Reset: usr_reset_n=0, i_start=0, i_cnt_flag=X for 2 cycles -> o_cnt_en=0, o_valid=0, sel_1=0 every cycle.
REQ-023 Full run: release reset with i_start=1, hold i_cnt_flag=0 for 63 cycles, then i_cnt_flag=1 for one cycle -> o_cnt_en=1 and sel_1=1 for 64 cycles, then o_valid=1 and o_cnt_en=0 for exactly one cycle, then IDLE outputs 0/0/0.
REQ-024 Abort: assert usr_reset_n=0 during COMPUTE (counter cycle 20) -> all outputs 0 after the next edge; with i_start=0, the block stays in IDLE after release.
REQ-025 Ignored inputs: pulse i_cnt_flag=1 while in IDLE -> no output change; drop i_start to 0 in COMPUTE -> o_cnt_en stays 1 until i_cnt_flag=1.
REQ-026 Back-to-back: hold i_start=1 through DONE -> o_valid pulse, one IDLE cycle (sel_1=0, o_cnt_en=0), then o_cnt_en=1 again.

Source files
------------

// File: rtl/cu_sha.sv
// Control FSM for a SHA-256 round engine: starts the external round counter,
// steers the datapath mux, and strobes o_valid when the final round completes.
module cu_sha (
  input  logic usr_clk,
  input  logic usr_reset_n,
  input  logic i_start,
  input  logic i_cnt_flag,
  output logic o_cnt_en,
  output logic o_valid,
  output logic sel_1
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the spare encoding falls back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = i_start ? COMPUTE : IDLE;
      COMPUTE: state_d = i_cnt_flag ? DONE : COMPUTE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: decoded from the state register only.
  always_comb begin
    o_cnt_en = 1'b0;
    o_valid  = 1'b0;
    sel_1    = 1'b0;
    case (state_q)
      COMPUTE: begin
        o_cnt_en = 1'b1;
        sel_1    = 1'b1;
      end
      DONE: begin
        o_valid = 1'b1;
        sel_1   = 1'b1;
      end
      default: begin
        o_cnt_en = 1'b0;
        o_valid  = 1'b0;
        sel_1    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cu_sha.sv
// Bench for cu_sha: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a run/pulse behavioural model.
module tb_cu_sha;

  logic usr_clk = 1'b0;
  logic usr_reset_n = 1'b0;
  logic i_start = 1'b0;
  logic i_cnt_flag = 1'b0;
  logic o_cnt_en, o_valid, sel_1;

  int tests = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: a hash run is either in progress, or its result pulse is showing.
  bit running = 1'b0;
  bit pulse   = 1'b0;

  always #5 usr_clk = ~usr_clk;

  cu_sha dut (
    .usr_clk    (usr_clk),
    .usr_reset_n(usr_reset_n),
    .i_start    (i_start),
    .i_cnt_flag (i_cnt_flag),
    .o_cnt_en   (o_cnt_en),
    .o_valid    (o_valid),
    .sel_1      (sel_1)
  );

  always @(posedge usr_clk) begin
    if (usr_reset_n !== 1'b1) begin
      running = 1'b0;
      pulse   = 1'b0;
    end else if (pulse) begin
      pulse = 1'b0;
    end else if (running) begin
      if (i_cnt_flag === 1'b1) begin
        running = 1'b0;
        pulse   = 1'b1;
      end
    end else if (i_start === 1'b1) begin
      running = 1'b1;
    end
  end

  // Every-cycle comparison against the model: counter enabled while running,
  // valid only on the result pulse, mux on feedback in either case.
  always @(negedge usr_clk) begin
    if (chk_en) begin
      tests++;
      if ({o_cnt_en, o_valid, sel_1} !== {running, pulse, running | pulse}) begin
        errors++;
        $display("FAIL model t=%0t got cnt_en/valid/sel=%b%b%b expected %b%b%b",
                 $time, o_cnt_en, o_valid, sel_1, running, pulse, running | pulse);
      end
    end
  end

  task automatic drive(input logic rst_n, input logic st, input logic fl);
    @(negedge usr_clk);
    #1;
    usr_reset_n = rst_n;
    i_start     = st;
    i_cnt_flag  = fl;
    @(posedge usr_clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [2:0] exp_v);
    tests++;
    if ({o_cnt_en, o_valid, sel_1} !== exp_v) begin
      errors++;
      $display("FAIL %s got cnt_en/valid/sel=%b%b%b expected %b", name,
               o_cnt_en, o_valid, sel_1, exp_v);
    end else begin
      $display("[TB] %s ok cnt_en/valid/sel=%b", name, exp_v);
    end
  endtask

  int en_cycles;

  initial begin
    // Reset with an undriven counter flag.
    drive(1'b0, 1'b0, 1'bx);
    lit("reset_cycle0", 3'b000);
    drive(1'b0, 1'b0, 1'bx);
    lit("reset_cycle1", 3'b000);
    chk_en = 1'b1;

    // Full 64-round run; start dropped after the first edge must not abort.
    drive(1'b1, 1'b1, 1'b0);
    lit("run_start", 3'b101);
    en_cycles = 1;
    for (int i = 0; i < 63; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (o_cnt_en === 1'b1) en_cycles++;
    end
    tests++;
    if (en_cycles != 64) begin
      errors++;
      $display("FAIL run_length got %0d cnt_en cycles expected 64", en_cycles);
    end else begin
      $display("[TB] run_length ok 64 cycles");
    end
    drive(1'b1, 1'b0, 1'b1);
    lit("run_done", 3'b011);
    drive(1'b1, 1'b0, 1'b0);
    lit("run_idle", 3'b000);

    // Counter flag is ignored while idle.
    drive(1'b1, 1'b0, 1'b1);
    lit("idle_flag0", 3'b000);
    drive(1'b1, 1'b0, 1'b1);
    lit("idle_flag1", 3'b000);

    // Abort at counter cycle 20, then stay idle with start low.
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) drive(1'b1, 1'b0, 1'b0);
    lit("abort_pre", 3'b101);
    drive(1'b0, 1'b1, 1'b1);
    lit("abort_reset", 3'b000);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    lit("abort_stay_idle", 3'b000);

    // Back-to-back runs with start held high.
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    lit("b2b_done", 3'b011);
    drive(1'b1, 1'b1, 1'b0);
    lit("b2b_gap", 3'b000);
    drive(1'b1, 1'b1, 1'b0);
    lit("b2b_restart", 3'b101);
    drive(1'b1, 1'b0, 1'b1);
    lit("b2b_done2", 3'b011);

    // Randomized traffic; the model check runs on every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 31) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
